// File: rtl/ebus_if.sv
// EBUS arbiter bundle: per-driver requests/data in, registered bus state and
// conflict diagnostics out. The slave modport is the arbiter side and the
// master modport is the driver/observer side.
interface ebus_if #(
  parameter int unsigned N_DRV  = 31,
  parameter int unsigned DATA_W = 36
) ();

  localparam int unsigned OWN_W = (N_DRV > 1) ? $clog2(N_DRV) : 1;

  logic [N_DRV-1:0]        drv_driving;
  logic [N_DRV*DATA_W-1:0] drv_data;
  logic [DATA_W-1:0]       ebus_data;
  logic [OWN_W-1:0]        ebus_owner;
  logic                    ebus_busy;
  logic                    ebus_xfer;
  logic                    clr_conflict;
  logic                    conflict;
  logic [7:0]              conflict_cnt;
  logic [N_DRV-1:0]        conflict_mask;

  modport slave (
    input  drv_driving,
    input  drv_data,
    input  clr_conflict,
    output ebus_data,
    output ebus_owner,
    output ebus_busy,
    output ebus_xfer,
    output conflict,
    output conflict_cnt,
    output conflict_mask
  );

  modport master (
    output drv_driving,
    output drv_data,
    output clr_conflict,
    input  ebus_data,
    input  ebus_owner,
    input  ebus_busy,
    input  ebus_xfer,
    input  conflict,
    input  conflict_cnt,
    input  conflict_mask
  );

endinterface

// File: rtl/ebus_arbiter.sv
// Synchronous EBUS data-path arbiter. Resolves N_DRV drivers each clock by
// fixed priority (MODE 0, index 0 highest) or wired-OR (MODE 1), registers
// the result, and lets an idle bus decay to 0 after KEEP_CYC idle cycles.
// Optional multi-driver diagnostics are built when EBUS_CONFLICT_CHK_EN is
// defined; otherwise the conflict outputs are constant 0.
module ebus_arbiter #(
  parameter int unsigned N_DRV    = 31,
  parameter int unsigned DATA_W   = 36,
  parameter int unsigned MODE     = 0,
  parameter int unsigned KEEP_CYC = 4
) (
  input logic   clk,
  input logic   reset,
  ebus_if.slave bus
);

  localparam int unsigned OWN_W  = (N_DRV > 1) ? $clog2(N_DRV) : 1;
  localparam int unsigned IDLE_W = (KEEP_CYC > 0) ? $clog2(KEEP_CYC + 1) : 1;
  localparam logic [IDLE_W-1:0] KeepVal = IDLE_W'(KEEP_CYC);

  logic                any_drv;
  logic [N_DRV-1:0]    grant;
  logic [N_DRV-1:0]    sel_mask;
  logic [OWN_W-1:0]    owner_sel;
  logic [DATA_W-1:0]   data_sel;

  logic [DATA_W-1:0]   data_d,  data_q;
  logic [OWN_W-1:0]    owner_d, owner_q;
  logic                busy_d,  busy_q;
  logic                xfer_d,  xfer_q;
  logic [IDLE_W-1:0]   idle_d,  idle_q;

  assign any_drv = |bus.drv_driving;

  // Priority encode: lowest set index wins, also produced as a one-hot grant.
  always_comb begin
    owner_sel = '0;
    grant     = '0;
    for (int i = int'(N_DRV) - 1; i >= 0; i--) begin
      if (bus.drv_driving[i]) begin
        owner_sel = OWN_W'(i);
        grant     = '0;
        grant[i]  = 1'b1;
      end
    end
  end

  // AND-OR data select; masking by the enable keeps X on idle channels out.
  always_comb begin
    sel_mask = (MODE == 1) ? bus.drv_driving : grant;
    data_sel = '0;
    for (int i = 0; i < int'(N_DRV); i++) begin
      data_sel = data_sel | (bus.drv_data[i*DATA_W +: DATA_W] & {DATA_W{sel_mask[i]}});
    end
  end

  // Next bus state: track active drivers, otherwise count idle and decay.
  always_comb begin
    data_d  = data_q;
    owner_d = owner_q;
    busy_d  = any_drv;
    xfer_d  = 1'b0;
    idle_d  = idle_q;
    if (any_drv) begin
      data_d  = data_sel;
      owner_d = owner_sel;
      idle_d  = '0;
      xfer_d  = !busy_q || (owner_sel != owner_q);
    end else begin
      if (idle_q != KeepVal) begin
        idle_d = idle_q + IDLE_W'(1);
      end
      // Decay lands on the edge where the counter reaches KEEP_CYC.
      if (idle_d == KeepVal) begin
        data_d = '0;
      end
    end
  end

  // Bus state registers; idle counter resets saturated so the bus starts decayed.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      xfer_q  <= 1'b0;
      idle_q  <= KeepVal;
    end else begin
      data_q  <= data_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      xfer_q  <= xfer_d;
      idle_q  <= idle_d;
    end
  end

  assign bus.ebus_data  = data_q;
  assign bus.ebus_owner = owner_q;
  assign bus.ebus_busy  = busy_q;
  assign bus.ebus_xfer  = xfer_q;

`ifdef EBUS_CONFLICT_CHK_EN

  logic               multi_drv;
  logic               cflag_d, cflag_q;
  logic [7:0]         ccnt_d,  ccnt_q;
  logic [N_DRV-1:0]   cmask_d, cmask_q;

  // Two or more bits set iff clearing the lowest set bit leaves something.
  assign multi_drv = |(bus.drv_driving & (bus.drv_driving - N_DRV'(1)));

  // Conflict status update; a conflict in the clear cycle restarts the record.
  always_comb begin
    cflag_d = cflag_q;
    ccnt_d  = ccnt_q;
    cmask_d = cmask_q;
    if (multi_drv) begin
      cflag_d = 1'b1;
      if (bus.clr_conflict) begin
        ccnt_d  = 8'd1;
        cmask_d = bus.drv_driving;
      end else begin
        ccnt_d = (ccnt_q == 8'd255) ? ccnt_q : ccnt_q + 8'd1;
        if (!cflag_q) begin
          cmask_d = bus.drv_driving;
        end
      end
    end else if (bus.clr_conflict) begin
      cflag_d = 1'b0;
      ccnt_d  = '0;
      cmask_d = '0;
    end
  end

  // Conflict status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cflag_q <= 1'b0;
      ccnt_q  <= '0;
      cmask_q <= '0;
    end else begin
      cflag_q <= cflag_d;
      ccnt_q  <= ccnt_d;
      cmask_q <= cmask_d;
    end
  end

  assign bus.conflict      = cflag_q;
  assign bus.conflict_cnt  = ccnt_q;
  assign bus.conflict_mask = cmask_q;

  // In priority mode a second driver silently loses its data, so flag it.
  a_no_multi_drv_prio : assert property (@(posedge clk) disable iff (reset)
    !((MODE == 0) && multi_drv))
    else $error("ebus_arbiter: multiple EBUS drivers 0x%0h", bus.drv_driving);

`else

  assign bus.conflict      = 1'b0;
  assign bus.conflict_cnt  = '0;
  assign bus.conflict_mask = '0;

`endif

endmodule

// File: tb/tb_ebus_arbiter.sv
// Directed bench for ebus_arbiter: a priority-mode instance (KEEP_CYC 4) and a
// wired-OR instance (KEEP_CYC 0) share clock and reset.
module tb_ebus_arbiter;

  localparam int unsigned NDRV = 31;
  localparam int unsigned DW   = 36;

  logic clk;
  logic reset;

  int n_checks;
  int n_fail;
  int n_xfer;

  ebus_if #(.N_DRV(NDRV), .DATA_W(DW)) if0 ();
  ebus_if #(.N_DRV(NDRV), .DATA_W(DW)) if1 ();

  ebus_arbiter #(.N_DRV(NDRV), .DATA_W(DW), .MODE(0), .KEEP_CYC(4)) u_dut0 (
    .clk  (clk),
    .reset(reset),
    .bus  (if0)
  );

  ebus_arbiter #(.N_DRV(NDRV), .DATA_W(DW), .MODE(1), .KEEP_CYC(0)) u_dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [DW-1:0] V5   = 36'o123456701234;
  localparam logic [DW-1:0] V0   = 36'o111111111111;
  localparam logic [DW-1:0] V7   = 36'o777700000007;
  localparam logic [DW-1:0] V7B  = 36'o000077770000;
  localparam logic [DW-1:0] V2   = 36'o000000000017;
  localparam logic [DW-1:0] V3   = 36'o770000000000;
  localparam logic [DW-1:0] V23  = 36'o770000000017;
  localparam logic [DW-1:0] V9   = 36'o525252525252;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_xfer   = 0;
    reset    = 1'b1;
    if0.drv_driving  = '0;
    if0.drv_data     = '0;
    if0.clr_conflict = 1'b0;
    if1.drv_driving  = '0;
    if1.drv_data     = '0;
    if1.clr_conflict = 1'b0;

    tick();
    tick();
    check_val("rst_data",  64'(if0.ebus_data), 64'h0);
    check_val("rst_owner", 64'(if0.ebus_owner), 64'h0);
    check_val("rst_busy",  64'(if0.ebus_busy), 64'h0);
    check_val("rst_xfer",  64'(if0.ebus_xfer), 64'h0);
    check_val("rst_cflag", 64'(if0.conflict), 64'h0);
    check_val("rst_ccnt",  64'(if0.conflict_cnt), 64'h0);
    check_val("rst_cmask", 64'(if0.conflict_mask), 64'h0);
    reset = 1'b0;

    // Idle after reset: nothing moves.
    for (int i = 0; i < 10; i++) begin
      tick();
      if (if0.ebus_xfer !== 1'b0 || if1.ebus_xfer !== 1'b0) n_xfer++;
      check_val("idle_data", 64'(if0.ebus_data | if1.ebus_data), 64'h0);
      check_val("idle_busy", 64'(if0.ebus_busy | if1.ebus_busy), 64'h0);
    end
    check_val("idle_xfer_cnt", 64'(n_xfer), 64'h0);

    // Channel 5 drives for three cycles; idle channel 6 carries garbage.
    if0.drv_data[5*DW +: DW] = V5;
    if0.drv_data[6*DW +: DW] = 36'o666666666666;
    if0.drv_driving[5] = 1'b1;
    tick();
    check_val("c5_data",  64'(if0.ebus_data), 64'(V5));
    check_val("c5_owner", 64'(if0.ebus_owner), 64'd5);
    check_val("c5_busy",  64'(if0.ebus_busy), 64'h1);
    check_val("c5_xfer",  64'(if0.ebus_xfer), 64'h1);
    tick();
    check_val("c5_xfer2", 64'(if0.ebus_xfer), 64'h0);
    check_val("c5_data2", 64'(if0.ebus_data), 64'(V5));
    tick();
    check_val("c5_xfer3", 64'(if0.ebus_xfer), 64'h0);
    if0.drv_driving = '0;
    if0.drv_data[5*DW +: DW] = '0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_val("keep_data", 64'(if0.ebus_data), 64'(V5));
    end
    check_val("keep_busy",  64'(if0.ebus_busy), 64'h0);
    check_val("keep_owner", 64'(if0.ebus_owner), 64'd5);
    tick();
    check_val("decay_data", 64'(if0.ebus_data), 64'h0);
    tick();
    check_val("decay_stay", 64'(if0.ebus_data), 64'h0);

    // Channels 0 and 7 together, then 7 alone, then 7 with new data.
    if0.drv_data[0*DW +: DW] = V0;
    if0.drv_data[7*DW +: DW] = V7;
    if0.drv_driving[0] = 1'b1;
    if0.drv_driving[7] = 1'b1;
    tick();
    check_val("p07_owner", 64'(if0.ebus_owner), 64'd0);
    check_val("p07_data",  64'(if0.ebus_data), 64'(V0));
    check_val("p07_xfer",  64'(if0.ebus_xfer), 64'h1);
    if0.drv_driving[0] = 1'b0;
    tick();
    check_val("p7_owner", 64'(if0.ebus_owner), 64'd7);
    check_val("p7_data",  64'(if0.ebus_data), 64'(V7));
    check_val("p7_xfer",  64'(if0.ebus_xfer), 64'h1);
    if0.drv_data[7*DW +: DW] = V7B;
    tick();
    check_val("p7_track", 64'(if0.ebus_data), 64'(V7B));
    check_val("p7_noxfer", 64'(if0.ebus_xfer), 64'h0);
`ifndef EBUS_CONFLICT_CHK_EN
    check_val("nocc_flag", 64'(if0.conflict), 64'h0);
    check_val("nocc_cnt",  64'(if0.conflict_cnt), 64'h0);
    check_val("nocc_mask", 64'(if0.conflict_mask), 64'h0);
`endif
    if0.drv_driving = '0;

    // Wired-OR instance: channels 2 and 3; KEEP_CYC 0 decays immediately.
    if1.drv_data[2*DW +: DW] = V2;
    if1.drv_data[3*DW +: DW] = V3;
    if1.drv_data[4*DW +: DW] = 36'o444444444444;
    if1.drv_driving[2] = 1'b1;
    if1.drv_driving[3] = 1'b1;
    tick();
    check_val("or_data",  64'(if1.ebus_data), 64'(V23));
    check_val("or_owner", 64'(if1.ebus_owner), 64'd2);
    check_val("or_xfer",  64'(if1.ebus_xfer), 64'h1);
    if1.drv_driving = '0;
    tick();
    check_val("or_decay", 64'(if1.ebus_data), 64'h0);
    check_val("or_busy",  64'(if1.ebus_busy), 64'h0);
    check_val("or_owner_hold", 64'(if1.ebus_owner), 64'd2);

`ifdef EBUS_CONFLICT_CHK_EN
    // Clear the record left by the 2/3 overlap, then saturate on {1,4}.
    if1.clr_conflict = 1'b1;
    tick();
    if1.clr_conflict = 1'b0;
    check_val("cc_pre_clr", 64'(if1.conflict_cnt), 64'h0);
    if1.drv_driving[1] = 1'b1;
    if1.drv_driving[4] = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    check_val("cc_flag", 64'(if1.conflict), 64'h1);
    check_val("cc_cnt",  64'(if1.conflict_cnt), 64'd255);
    check_val("cc_mask", 64'(if1.conflict_mask), 64'h12);
    if1.drv_driving = '0;
    if1.clr_conflict = 1'b1;
    tick();
    check_val("cc_clr_flag", 64'(if1.conflict), 64'h0);
    check_val("cc_clr_cnt",  64'(if1.conflict_cnt), 64'h0);
    check_val("cc_clr_mask", 64'(if1.conflict_mask), 64'h0);
    if1.drv_driving[2] = 1'b1;
    if1.drv_driving[3] = 1'b1;
    tick();
    tick();
    if1.drv_driving = '0;
    if1.drv_driving[1] = 1'b1;
    if1.drv_driving[4] = 1'b1;
    tick();
    check_val("cc_win_flag", 64'(if1.conflict), 64'h1);
    check_val("cc_win_cnt",  64'(if1.conflict_cnt), 64'h1);
    check_val("cc_win_mask", 64'(if1.conflict_mask), 64'h12);
    if1.clr_conflict = 1'b0;
    if1.drv_driving = '0;
    tick();
`endif

    // Reset while channel 9 drives, then release with 9 still driving.
    if0.drv_data[9*DW +: DW] = V9;
    if0.drv_driving[9] = 1'b1;
    tick();
    check_val("c9_owner", 64'(if0.ebus_owner), 64'd9);
    reset = 1'b1;
    tick();
    check_val("rst9_data",  64'(if0.ebus_data), 64'h0);
    check_val("rst9_busy",  64'(if0.ebus_busy), 64'h0);
    check_val("rst9_owner", 64'(if0.ebus_owner), 64'h0);
    check_val("rst9_xfer",  64'(if0.ebus_xfer), 64'h0);
    reset = 1'b0;
    tick();
    check_val("post9_xfer", 64'(if0.ebus_xfer), 64'h1);
    check_val("post9_data", 64'(if0.ebus_data), 64'(V9));
    tick();
    check_val("post9_xfer_once", 64'(if0.ebus_xfer), 64'h0);
    if0.drv_driving = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
